// File: rtl/mdu_e_if.sv
// Handshake and result bundle between decode/hazard logic and the
// execute-stage multiply/divide unit.
interface mdu_e_if;
  logic        Start_E_I;
  logic [2:0]  MDOp_E_I;
  logic [31:0] A_E_I;
  logic [31:0] B_E_I;
  logic        Busy_E_O;
  logic [31:0] HI_E_O;
  logic [31:0] LO_E_O;

  modport master (
    output Start_E_I,
    output MDOp_E_I,
    output A_E_I,
    output B_E_I,
    input  Busy_E_O,
    input  HI_E_O,
    input  LO_E_O
  );

  modport slave (
    input  Start_E_I,
    input  MDOp_E_I,
    input  A_E_I,
    input  B_E_I,
    output Busy_E_O,
    output HI_E_O,
    output LO_E_O
  );
endinterface

// File: rtl/mdu_e.sv
// Execute-stage multiply/divide unit: fixed-latency MULT/DIV into
// private HI/LO plus zero-latency MTHI/MTLO.
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic     clk,
  input logic     reset,
  mdu_e_if.slave  bus
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  localparam logic [3:0] MUL_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        done;
  logic        can_start;
  logic        is_md;
  logic        is_mthi;
  logic        is_mtlo;

  logic [63:0] ea, eb, prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, den;
  logic [31:0] q_mag, r_mag;
  logic [31:0] res_hi, res_lo;

  // op_q[1] selects divide, op_q[0] selects unsigned
  always_comb begin
    ea    = op_q[0] ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
    eb    = op_q[0] ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
    prod  = ea * eb;
    neg_a = !op_q[0] && a_q[31];
    neg_b = !op_q[0] && b_q[31];
    mag_a = neg_a ? -a_q : a_q;
    mag_b = neg_b ? -b_q : b_q;
    den   = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_mag = mag_a / den;
    r_mag = mag_a % den;
    if (op_q[1]) begin
      res_lo = (neg_a ^ neg_b) ? -q_mag : q_mag;
      res_hi = neg_a ? -r_mag : r_mag;
    end else begin
      res_lo = prod[31:0];
      res_hi = prod[63:32];
    end
  end

  assign done      = (state_q == S_BUSY) && (cnt_q == 4'd1);
  assign can_start = (state_q == S_IDLE) || done;
  assign is_md     = !bus.MDOp_E_I[2];
  assign is_mthi   = bus.MDOp_E_I == 3'b100;
  assign is_mtlo   = bus.MDOp_E_I == 3'b101;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == S_BUSY) begin
      cnt_d = cnt_q - 4'd1;
      if (done) begin
        state_d = S_IDLE;
        // divide by zero leaves HI/LO untouched
        if (!(op_q[1] && b_q == 32'd0)) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
    end
    if (bus.Start_E_I && can_start) begin
      unique case (1'b1)
        is_md: begin
          a_d     = bus.A_E_I;
          b_d     = bus.B_E_I;
          op_d    = bus.MDOp_E_I[1:0];
          cnt_d   = bus.MDOp_E_I[1] ? DIV_N : MUL_N;
          state_d = S_BUSY;
        end
        is_mthi: hi_d = bus.A_E_I;
        is_mtlo: lo_d = bus.A_E_I;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.Busy_E_O = (state_q == S_BUSY);
  assign bus.HI_E_O   = hi_q;
  assign bus.LO_E_O   = lo_q;

endmodule

// File: tb/tb_mdu_e.sv
// Bench for mdu_e: directed scenarios with literal results plus a
// randomized run, all against an arithmetic reference model.
module tb_mdu_e;

  localparam int MN = 5;
  localparam int DN = 10;

  logic clk;
  logic reset;
  mdu_e_if bif ();

  mdu_e #(.MULT_CYCLES(MN), .DIV_CYCLES(DN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // reference model state
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [2:0]  m_op;
  int          m_rem;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_finish();
    longint sa, sb, q, r;
    longint unsigned up;
    case (m_op)
      3'd0: begin
        sa = longint'($signed(m_a));
        sb = longint'($signed(m_b));
        q  = sa * sb;
        m_hi = q[63:32];
        m_lo = q[31:0];
      end
      3'd1: begin
        up = {32'b0, m_a} * {32'b0, m_b};
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      3'd2: if (m_b != 0) begin
        sa = longint'($signed(m_a));
        sb = longint'($signed(m_b));
        q  = sa / sb;
        r  = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      default: if (m_b != 0) begin
        m_lo = m_a / m_b;
        m_hi = m_a % m_b;
      end
    endcase
  endtask

  task automatic model_step();
    bit fin, idle;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_rem = 0;
      m_a = 0; m_b = 0; m_op = 0;
      return;
    end
    fin  = (m_rem == 1);
    idle = (m_rem == 0);
    if (m_rem > 0) m_rem--;
    if (fin) model_finish();
    if (bif.Start_E_I && (idle || fin)) begin
      if (bif.MDOp_E_I < 3'd4) begin
        m_op  = bif.MDOp_E_I;
        m_a   = bif.A_E_I;
        m_b   = bif.B_E_I;
        m_rem = bif.MDOp_E_I[1] ? DN : MN;
      end else if (bif.MDOp_E_I == 3'd4) m_hi = bif.A_E_I;
      else if (bif.MDOp_E_I == 3'd5) m_lo = bif.A_E_I;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, bif.Busy_E_O}, {31'b0, m_rem != 0});
      chk("hi", bif.HI_E_O, m_hi);
      chk("lo", bif.LO_E_O, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wait_n(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    bif.Start_E_I = 1'b1;
    bif.MDOp_E_I  = op;
    bif.A_E_I     = a;
    bif.B_E_I     = b;
    tick();
    bif.Start_E_I = 1'b0;
    bif.A_E_I     = $urandom;
    bif.B_E_I     = $urandom;
  endtask

  initial begin
    reset = 1'b1;
    bif.Start_E_I = 1'b0;
    bif.MDOp_E_I  = 3'd0;
    bif.A_E_I     = 32'd0;
    bif.B_E_I     = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    chk_en = 1;
    chk("rst_busy", {31'b0, bif.Busy_E_O}, 32'd0);
    chk("rst_hi", bif.HI_E_O, 32'd0);
    chk("rst_lo", bif.LO_E_O, 32'd0);

    issue(3'd0, 32'hFFFFFFFD, 32'd5);
    wait_n(MN - 1);
    chk("mult_busy_t4", {31'b0, bif.Busy_E_O}, 32'd1);
    chk("mult_hi_old", bif.HI_E_O, 32'd0);
    tick();
    chk("mult_hi", bif.HI_E_O, 32'hFFFFFFFF);
    chk("mult_lo", bif.LO_E_O, 32'hFFFFFFF1);

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_n(MN);
    chk("multu_hi", bif.HI_E_O, 32'hFFFFFFFE);
    chk("multu_lo", bif.LO_E_O, 32'h00000001);

    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_n(DN);
    chk("div_lo", bif.LO_E_O, 32'hFFFFFFFD);
    chk("div_hi", bif.HI_E_O, 32'hFFFFFFFF);
    issue(3'd3, 32'd7, 32'd2);
    wait_n(DN);
    chk("divu_lo", bif.LO_E_O, 32'd3);
    chk("divu_hi", bif.HI_E_O, 32'd1);

    issue(3'd4, 32'h12345678, 32'd0);
    chk("mthi", bif.HI_E_O, 32'h12345678);
    issue(3'd5, 32'h9ABCDEF0, 32'd0);
    chk("mtlo", bif.LO_E_O, 32'h9ABCDEF0);
    chk("mt_busy", {31'b0, bif.Busy_E_O}, 32'd0);

    issue(3'd2, 32'd5, 32'd0);
    wait_n(DN - 1);
    chk("dz_busy", {31'b0, bif.Busy_E_O}, 32'd1);
    tick();
    chk("dz_busy_end", {31'b0, bif.Busy_E_O}, 32'd0);
    chk("dz_hi", bif.HI_E_O, 32'h12345678);
    chk("dz_lo", bif.LO_E_O, 32'h9ABCDEF0);

    issue(3'd2, 32'd100, 32'd7);
    wait_n(2);
    issue(3'd5, 32'hDEADBEEF, 32'd0);
    issue(3'd0, 32'd3, 32'd4);
    wait_n(5);
    issue(3'd0, 32'd6, 32'd7);
    chk("b2b_lo", bif.LO_E_O, 32'd14);
    chk("b2b_hi", bif.HI_E_O, 32'd2);
    chk("b2b_busy", {31'b0, bif.Busy_E_O}, 32'd1);
    wait_n(MN);
    chk("b2b_mul_lo", bif.LO_E_O, 32'd42);
    chk("b2b_mul_hi", bif.HI_E_O, 32'd0);

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_n(DN);
    chk("ovf_lo", bif.LO_E_O, 32'h80000000);
    chk("ovf_hi", bif.HI_E_O, 32'd0);

    issue(3'd2, 32'd1000, 32'd3);
    wait_n(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'b0, bif.Busy_E_O}, 32'd0);
    chk("abort_hi", bif.HI_E_O, 32'd0);
    wait_n(DN + 2);
    chk("abort_lo", bif.LO_E_O, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      bif.Start_E_I = ($urandom_range(0, 2) == 0);
      bif.MDOp_E_I  = 3'($urandom_range(0, 7));
      bif.A_E_I     = $urandom;
      case ($urandom_range(0, 7))
        0: bif.B_E_I = 32'd0;
        1: bif.B_E_I = 32'($urandom_range(1, 9));
        2: bif.B_E_I = 32'hFFFFFFFF;
        default: bif.B_E_I = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) bif.A_E_I = 32'h80000000;
      tick();
    end
    reset = 1'b0;
    bif.Start_E_I = 1'b0;
    wait_n(DN + 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_e.md
Name: mdu_e

Overview:
- Multiply/divide unit in the execute stage, directly downstream of the decode stage.
- Consumes the forwarded register operands that decode produces, plus a multiply/divide opcode pipelined from decode.
- Runs multi-cycle MULT/MULTU/DIV/DIVU into private HI/LO registers and executes MTHI/MTLO.
- Exposes Busy_E_O so the hazard unit can stall any multiply/divide instruction that follows while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, cycles Busy_E_O stays high for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, cycles Busy_E_O stays high for DIV/DIVU (legal range 1..15)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- Start_E_I  in  1  opcode valid this cycle; one-cycle pulse per instruction
- MDOp_E_I  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved
- A_E_I  in  32  rs operand (already forwarded)
- B_E_I  in  32  rt operand (already forwarded)
- Busy_E_O  out  1  operation in flight
- HI_E_O  out  32  architectural HI
- LO_E_O  out  32  architectural LO

Behaviour:
- Reset (clk edge with reset=1): HI=0, LO=0, Busy=0, counter=0, latched operands/op cleared. Reset overrides Start in the same cycle.
- Reset mid-operation aborts the operation; HI/LO still end at 0.
- Accept rule: Start_E_I=1 and Busy=0 at an edge. The accepting edge is T.
- Start_E_I=1 while Busy=1: ignored entirely, including MTHI/MTLO. The hazard unit guarantees this never occurs; the block itself must not corrupt state.
- Reserved opcodes: ignored, no state change.
- MULT/MULTU/DIV/DIVU accepted at edge T:
  - latch A, B and op; counter=N, where N = MULT_CYCLES for multiply or DIV_CYCLES for divide; Busy=1.
  - each following edge decrements counter.
  - at the edge where counter goes 1 -> 0: write HI/LO and set Busy=0.
  - Busy is therefore high for exactly N cycles after T; new HI/LO are visible after edge T+N.
  - a new Start may be accepted at edge T+N, the same edge that writes the previous result.
- MTHI/MTLO accepted at edge T: HI (or LO) = A_E_I at T, Busy stays 0, no latency.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI = product[63:32], LO = product[31:0].
  - MULTU: same, unsigned.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - 0x80000000 / 0xFFFFFFFF (DIV): LO = 0x80000000, HI = 0; no trap.
  - Division by zero: the operation still occupies DIV_CYCLES cycles of Busy, then HI/LO remain unchanged.
- Operands are latched at T. Later changes on A_E_I/B_E_I (forwarding updates, stalls, flushes upstream) must not affect the result.
- HI_E_O/LO_E_O are driven directly from registers. During Busy they show the old values; the hazard unit stalls MFHI/MFLO while busy.
- Start_E_I=0 has no effect; an in-flight operation continues unaffected.

Test Plan:
- Reset, then pulse MULT, A=0xFFFFFFFD (-3), B=5 -> Busy high for 5 cycles; after edge T+5, HI=0xFFFFFFFF, LO=0xFFFFFFF1; HI/LO read 0 through T+4.
- MULTU, A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 cycles. Then DIVU A=7, B=2 -> LO=3, HI=1.
- MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 on consecutive cycles -> HI/LO updated one edge after each; Busy never asserts. Then DIV by B=0 -> Busy 10 cycles, HI/LO unchanged.
- Start DIV, then during Busy pulse MTLO A=0xDEADBEEF and a MULT with changed A/B -> both ignored; DIV result correct. Back-to-back MULT accepted at edge T+10 with Busy continuous.
- Assert reset at cycle T+3 of a DIV -> next edge Busy=0, HI=LO=0; no later write occurs.
